// File: rtl/fifo_burst_reader_if.sv
// fifo_burst_reader_if: FIFO read-side and stream-output bundle for the burst reader
interface fifo_burst_reader_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4
);
  logic [DATA_WIDTH-1:0] fifo_rd_data;
  logic                  fifo_empty;
  logic [ADDR_WIDTH:0]   fifo_count;
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic                  m_last;
  modport master (
    input  fifo_rd_data, fifo_empty, fifo_count, m_ready,
    output fifo_rd_en, m_data, m_valid, m_last
  );
  modport slave (
    output fifo_rd_data, fifo_empty, fifo_count, m_ready,
    input  fifo_rd_en, m_data, m_valid, m_last
  );
endinterface

// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: pops full or timed-out/flushed partial bursts from a FIFO onto a valid/ready stream
module fifo_burst_reader #(
  parameter int DATA_WIDTH     = 16,
  parameter int ADDR_WIDTH     = 4,
  parameter int BURST_LEN      = 8,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                rd_clk,
  input  logic                rd_rst,
  input  logic                flush,
  fifo_burst_reader_if.master bus,
  output logic                burst_active,
  output logic                partial,
  output logic [15:0]         burst_count
);
  localparam int CW = ADDR_WIDTH + 1;
  localparam int TW = TIMEOUT_CYCLES < 2 ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] BL   = CW'(BURST_LEN);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);
  localparam logic          TO_EN = TIMEOUT_CYCLES != 0;

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         remaining_q, remaining_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic                  m_valid_q, m_valid_d;
  logic                  m_last_q, m_last_d;
  logic                  partial_q, partial_d;
  logic [15:0]           burst_count_q, burst_count_d;
  logic                  go_full, go_part, pop, hs, done;

  // Burst decision in IDLE, pop/handshake bookkeeping in STREAM.
  always_comb begin
    go_full       = state_q == IDLE && bus.fifo_count >= BL;
    go_part       = state_q == IDLE && !go_full && bus.fifo_count != '0 &&
                    (flush || (TO_EN && timer_q == TMAX));
    pop           = state_q == STREAM && remaining_q != '0 && !bus.fifo_empty &&
                    (!m_valid_q || bus.m_ready);
    hs            = m_valid_q && bus.m_ready;
    done          = hs && m_last_q;
    state_d       = (go_full || go_part) ? STREAM : done ? IDLE : state_q;
    remaining_d   = go_full ? BL : go_part ? bus.fifo_count :
                    pop ? remaining_q - CW'(1) : remaining_q;
    timer_d       = (state_q == IDLE && !go_full && !go_part && !bus.fifo_empty) ?
                    (timer_q == TMAX ? timer_q : timer_q + TW'(1)) : '0;
    m_data_d      = pop ? bus.fifo_rd_data : m_data_q;
    m_valid_d     = pop ? 1'b1 : hs ? 1'b0 : m_valid_q;
    m_last_d      = pop ? remaining_q == CW'(1) : hs ? 1'b0 : m_last_q;
    partial_d     = go_full ? 1'b0 : go_part ? 1'b1 : partial_q;
    burst_count_d = done ? burst_count_q + 16'd1 : burst_count_q;
  end

  // State and registered stream outputs; reset asserts asynchronously.
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      state_q       <= IDLE;
      remaining_q   <= '0;
      timer_q       <= '0;
      m_data_q      <= '0;
      m_valid_q     <= 1'b0;
      m_last_q      <= 1'b0;
      partial_q     <= 1'b0;
      burst_count_q <= '0;
    end else begin
      state_q       <= state_d;
      remaining_q   <= remaining_d;
      timer_q       <= timer_d;
      m_data_q      <= m_data_d;
      m_valid_q     <= m_valid_d;
      m_last_q      <= m_last_d;
      partial_q     <= partial_d;
      burst_count_q <= burst_count_d;
    end
  end

  assign bus.fifo_rd_en = pop;
  assign bus.m_data     = m_data_q;
  assign bus.m_valid    = m_valid_q;
  assign bus.m_last     = m_last_q;
  assign burst_active   = state_q == STREAM;
  assign partial        = partial_q;
  assign burst_count    = burst_count_q;
endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb_fifo_burst_reader: directed scoreboard bench with a behavioural show-ahead FIFO
module tb_fifo_burst_reader;
  logic        rd_clk = 1'b0;
  logic        rd_rst = 1'b1;
  logic        flush  = 1'b0;
  logic        burst_active, partial;
  logic [15:0] burst_count;

  fifo_burst_reader_if #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) bus ();

  fifo_burst_reader #(
    .DATA_WIDTH(16), .ADDR_WIDTH(4), .BURST_LEN(8), .TIMEOUT_CYCLES(16)
  ) dut (
    .rd_clk(rd_clk), .rd_rst(rd_rst), .flush(flush), .bus(bus),
    .burst_active(burst_active), .partial(partial), .burst_count(burst_count)
  );

  always #5 rd_clk = ~rd_clk;

  int          checks = 0;
  int          errors = 0;
  int          hs_cnt = 0;
  int          ready_mode = 0;
  int          ready_idx = 0;
  logic [3:0]  ready_pat = 4'b1001;
  logic [15:0] fq[$];
  logic [15:0] wq[$];
  logic [16:0] exp_q[$];
  logic        en_s;

  task automatic check(string name, logic [31:0] act, logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, want);
    end
  endtask

  task automatic refresh();
    bus.fifo_empty   = fq.size() == 0;
    bus.fifo_count   = 5'(fq.size());
    bus.fifo_rd_data = fq.size() != 0 ? fq[0] : 16'h0;
  endtask

  task automatic tick();
    @(posedge rd_clk);
    #2;
  endtask

  task automatic push_burst(logic [15:0] start, int n);
    for (int i = 0; i < n; i++) begin
      wq.push_back(start + 16'(i));
      exp_q.push_back({i == n - 1, start + 16'(i)});
    end
  endtask

  task automatic wait_bc(logic [15:0] target, int budget, string name);
    for (int i = 0; i < budget && burst_count != target; i++) tick();
    check(name, burst_count, target);
  endtask

  // Show-ahead FIFO model: one write per cycle, pops follow the sampled rd_en.
  initial begin
    fq.delete();
    refresh();
    forever begin
      @(negedge rd_clk);
      if (wq.size() != 0) fq.push_back(wq.pop_front());
      refresh();
      #4;
      en_s = bus.fifo_rd_en;
      if (en_s) begin
        checks++;
        if (!burst_active) begin
          errors++;
          $display("FAIL rd_en_outside_stream actual=1 expected=0");
        end
      end
      @(posedge rd_clk);
      #1;
      if (en_s) begin
        if (fq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_of_empty_fifo actual=empty expected=data");
        end else void'(fq.pop_front());
      end
      refresh();
    end
  end

  // Sink ready: constant 1 or the repeating 1,0,0,1 pattern.
  initial begin
    bus.m_ready = 1'b1;
    forever begin
      @(negedge rd_clk);
      bus.m_ready = ready_mode != 0 ? ready_pat[ready_idx[1:0]] : 1'b1;
      ready_idx++;
    end
  end

  // Monitor: scoreboard compare on every handshake and hold check during stalls.
  initial begin
    logic        stall;
    logic [15:0] hold_d;
    logic        hold_l;
    logic [16:0] e;
    stall = 1'b0;
    hold_d = '0;
    hold_l = 1'b0;
    forever begin
      @(negedge rd_clk);
      #4;
      if (rd_rst) stall = 1'b0;
      else begin
        if (stall) begin
          checks++;
          if (!bus.m_valid || bus.m_data !== hold_d || bus.m_last !== hold_l) begin
            errors++;
            $display("FAIL stall_hold actual=%b/%h/%b expected=1/%h/%b",
                     bus.m_valid, bus.m_data, bus.m_last, hold_d, hold_l);
          end
        end
        if (bus.m_valid && bus.m_ready) begin
          hs_cnt++;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL stream_word actual=%h expected=none", {bus.m_last, bus.m_data});
          end else begin
            e = exp_q.pop_front();
            if ({bus.m_last, bus.m_data} !== e) begin
              errors++;
              $display("FAIL stream_word actual=%h expected=%h", {bus.m_last, bus.m_data}, e);
            end
          end
        end
        stall  = bus.m_valid && !bus.m_ready;
        hold_d = bus.m_data;
        hold_l = bus.m_last;
      end
    end
  end

  initial begin
    int ones, runs, k, base;
    logic prev;
    repeat (2) tick();
    check("rst_m_valid", bus.m_valid, 0);
    check("rst_m_last", bus.m_last, 0);
    check("rst_m_data", bus.m_data, 0);
    check("rst_partial", partial, 0);
    check("rst_burst_active", burst_active, 0);
    check("rst_burst_count", burst_count, 0);
    check("rst_rd_en", bus.fifo_rd_en, 0);
    @(negedge rd_clk);
    rd_rst = 1'b0;
    tick();

    push_burst(16'h0001, 8);
    ones = 0;
    runs = 0;
    prev = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bus.fifo_rd_en) begin
        ones++;
        if (!prev) runs++;
      end
      prev = bus.fifo_rd_en;
    end
    check("full_pop_pulses", ones, 8);
    check("full_pop_runs", runs, 1);
    check("full_burst_count", burst_count, 1);
    check("full_partial", partial, 0);
    check("full_back_idle", burst_active, 0);

    push_burst(16'h0011, 3);
    k = 0;
    for (int i = 1; i <= 40 && k == 0; i++) begin
      tick();
      if (bus.fifo_rd_en) k = i;
    end
    check("timeout_first_pop_cycle", k, 17);
    check("timeout_partial", partial, 1);
    wait_bc(16'd2, 20, "timeout_burst_count");

    push_burst(16'h0021, 2);
    repeat (4) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_active", burst_active, 1);
    check("flush_partial", partial, 1);
    wait_bc(16'd3, 20, "flush_burst_count");
    repeat (3) tick();
    flush = 1'b1;
    repeat (3) begin
      tick();
      check("flush_empty_idle", burst_active, 0);
    end
    flush = 1'b0;
    tick();
    check("flush_empty_rd_en", bus.fifo_rd_en, 0);
    check("flush_empty_count", burst_count, 3);

    push_burst(16'h0031, 8);
    repeat (7) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("full_beats_flush_active", burst_active, 1);
    check("full_beats_flush_partial", partial, 0);
    wait_bc(16'd4, 30, "full_beats_flush_count");

    ready_mode = 1;
    push_burst(16'h0041, 8);
    push_burst(16'h0049, 8);
    wait_bc(16'd6, 200, "stall_two_bursts_count");
    ready_mode = 0;
    check("stall_partial", partial, 0);

    push_burst(16'h0051, 8);
    base = hs_cnt;
    for (int i = 0; i < 60 && hs_cnt < base + 3; i++) tick();
    check("reset_after_three", hs_cnt - base, 3);
    rd_rst = 1'b1;
    #1;
    check("reset_m_valid_now", bus.m_valid, 0);
    exp_q.delete();
    fq.delete();
    wq.delete();
    repeat (3) begin
      tick();
      check("reset_rd_en", bus.fifo_rd_en, 0);
      check("reset_m_valid", bus.m_valid, 0);
      check("reset_active", burst_active, 0);
      check("reset_burst_count", burst_count, 0);
    end
    @(negedge rd_clk);
    rd_rst = 1'b0;
    tick();
    push_burst(16'h0061, 8);
    wait_bc(16'd1, 40, "recover_burst_count");
    check("recover_partial", partial, 0);

    repeat (3) tick();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fifo_burst_reader.md
Name: fifo_burst_reader

Overview:
- Sits directly downstream of the asynchronous count FIFO, in the read-clock domain.
- Watches the FIFO's read-side occupancy count and, once a full burst of words is present, pops exactly that many words.
- Presents the popped words on a registered valid/ready stream output and marks the final word with m_last.
- Sends a partial burst when the FIFO has held data for a timeout period or when software asserts flush.

Parameters:
- DATA_WIDTH, 16, word width; must match the FIFO's data width.
- ADDR_WIDTH, 4, FIFO address width; the count input is ADDR_WIDTH+1 bits.
- BURST_LEN, 8, words per full burst; legal range 1..2^ADDR_WIDTH.
- TIMEOUT_CYCLES, 256, idle cycles with data present before a partial burst is sent; 0 disables the timeout.

Ports:
- rd_clk  in  1  read-domain clock.
- rd_rst  in  1  reset; asynchronous, active-high.
- fifo_rd_data  in  DATA_WIDTH  FIFO show-ahead head word; valid whenever fifo_empty=0.
- fifo_empty  in  1  FIFO empty flag.
- fifo_count  in  ADDR_WIDTH+1  FIFO read-side occupancy count; a lower bound on true occupancy.
- fifo_rd_en  out  1  pop strobe to the FIFO.
- flush  in  1  level; forces a partial burst while in IDLE.
- m_data  out  DATA_WIDTH  stream data.
- m_valid  out  1  stream valid.
- m_ready  in  1  stream ready.
- m_last  out  1  final word of the burst.
- burst_active  out  1  high while in the STREAM state.
- partial  out  1  current or most recent burst was shorter than BURST_LEN.
- burst_count  out  16  completed bursts; wraps modulo 2^16.

Behaviour:
- Reset (asynchronous assert, synchronous deassert into rd_clk):
  - State = IDLE.
  - m_valid, m_last, m_data, partial, burst_active, burst_count, timer and remaining all = 0.
  - fifo_rd_en = 0.
- State IDLE:
  - timer increments each cycle while fifo_empty=0 and saturates at TIMEOUT_CYCLES; it clears when fifo_empty=1.
  - If fifo_count >= BURST_LEN: load remaining=BURST_LEN, set partial=0, go to STREAM. This takes priority over flush and timeout.
  - Else if fifo_count != 0 and (flush=1, or TIMEOUT_CYCLES!=0 and timer==TIMEOUT_CYCLES): load remaining=fifo_count, set partial=1, go to STREAM.
  - No transition if fifo_count=0, even with flush=1.
- State STREAM:
  - burst_active=1. The timer is held at 0 and flush is ignored.
  - pop = (remaining!=0) and (fifo_empty=0) and (m_valid=0 or m_ready=1).
  - fifo_rd_en = pop. It is combinational and is never high outside STREAM.
  - On a pop edge: m_data <= fifo_rd_data, m_valid <= 1, m_last <= (remaining==1), remaining decrements.
  - On an edge with m_valid and m_ready and no pop: m_valid <= 0, m_last <= 0.
  - When m_valid, m_ready and m_last are all 1: the next state is IDLE, burst_count increments, and the timer clears.
- Latency:
  - The decision edge enters STREAM.
  - The first pop occurs in the next cycle, so m_valid rises 2 edges after the qualifying condition is sampled.
  - With m_ready held at 1, throughput is 1 word per cycle with no bubbles.
- Stream rules:
  - m_data and m_last hold stable while m_valid=1 and m_ready=0.
  - m_valid never drops without a handshake.
  - m_ready may toggle arbitrarily.
- Because fifo_count is a lower bound on occupancy, the latched length is always available. The fifo_empty guard is kept as a defensive check; a stall on it must not lose or duplicate words.
- Words popped before a reset are discarded. The FIFO pointers are reset by their own domain resets, not by this block.
- Width rules:
  - remaining is ADDR_WIDTH+1 bits.
  - timer is sized to hold TIMEOUT_CYCLES (minimum 1 bit).
  - Comparisons are unsigned.

Test Plan:
- Write 8 words 0x0001..0x0008, m_ready=1 → fifo_rd_en pulses for 8 consecutive cycles; m_data 0x0001..0x0008 appear on consecutive cycles; m_last only on 0x0008; partial=0; burst_count=1.
- Write 3 words, TIMEOUT_CYCLES=16, no flush → no pop for 16 idle cycles, then a 3-word burst with m_last on the third word; partial=1.
- Write 2 words, assert flush for 1 cycle → a 2-word partial burst. Flush with the FIFO empty → no activity, burst_count unchanged.
- Write 16 words, m_ready toggling 1,0,0,1 → two bursts of 8 each; every word delivered exactly once and in order; m_data stable during stalls; burst_count=2.
- Assert rd_rst after 3 of 8 words have been delivered → m_valid=0 immediately; state IDLE; burst_count=0; fifo_rd_en=0 throughout reset.
- Set fifo_count=8 and flush=1 in the same cycle → full burst with partial=0.
